// File: rtl/press_if.sv
// Press event bundle from the button front-end to its consumers.
//   press       one-cycle pulse on each debounced press
//   released    one-cycle pulse on each debounced release
//   long_press  one-cycle pulse after a press has been held long enough
//   btn_state   debounced button level
//   run         run/hold level, toggled by every press
interface press_if;
  logic press;
  logic released;
  logic long_press;
  logic btn_state;
  logic run;

  modport master (output press, released, long_press, btn_state, run);
  modport slave  (input  press, released, long_press, btn_state, run);
endinterface

// File: rtl/press_pulse_gen.sv
// Push-button front-end: synchronizes and debounces a raw button level and
// emits registered press/release/long-press pulses, a debounced level and a
// run/hold toggle.
//   clk  system clock, rising edge
//   rst  synchronous active-low reset
//   btn  raw asynchronous, bouncy button level
//   evt  press_if master: press, released, long_press, btn_state, run
module press_pulse_gen #(
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned LONG_CYCLES = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     btn,
  press_if.master  evt
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PREV = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t            state;
  logic              s1;
  logic              btn_s;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // Synchronizer, debounce FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      s1             <= 1'b0;
      btn_s          <= 1'b0;
      db_cnt         <= '0;
      hold_cnt       <= '0;
      evt.press      <= 1'b0;
      evt.released   <= 1'b0;
      evt.long_press <= 1'b0;
      evt.btn_state  <= 1'b0;
      evt.run        <= 1'b0;
    end else begin
      s1             <= btn;
      btn_s          <= s1;
      evt.press      <= 1'b0;
      evt.released   <= 1'b0;
      evt.long_press <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS_WAIT;
            db_cnt <= DB_W'(1);
          end
        end

        PRESS_WAIT: begin
          if (!btn_s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state         <= HELD;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            evt.press     <= 1'b1;
            evt.run       <= ~evt.run;
            evt.btn_state <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end

        HELD: begin
          if (!btn_s) begin
            state  <= RELEASE_WAIT;
            db_cnt <= DB_W'(1);
          end else if (hold_cnt != HOLD_MAX) begin
            // Saturation makes long_press a one-shot even after release bounces.
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (hold_cnt == HOLD_PREV) evt.long_press <= 1'b1;
          end
        end

        RELEASE_WAIT: begin
          // hold_cnt is deliberately left untouched so a bounce resumes it.
          if (btn_s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            db_cnt        <= '0;
            evt.released  <= 1'b1;
            evt.btn_state <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
